// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states, instruction fields, flag bits.
package cpu_pkg;

    localparam int INSTR_W = 32;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd11;
    localparam logic [3:0] OP_RET  = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd13;
    localparam logic [3:0] OP_IN   = 4'd14;
    localparam logic [3:0] OP_ILL  = 4'd15;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam int OP_HI      = 31;
    localparam int OP_LO      = 28;
    localparam int A_TYPE_BIT = 27;
    localparam int A_HI       = 26;
    localparam int A_LO       = 19;
    localparam int B_TYPE_BIT = 18;
    localparam int B_HI       = 17;
    localparam int B_LO       = 10;

    localparam int FLG_ILLEGAL   = 7;
    localparam int FLG_STK_UNDER = 6;
    localparam int FLG_STK_OVER  = 5;
    localparam int FLG_SHIFT_OVF = 4;
    localparam int FLG_CARRY     = 3;
    localparam int FLG_ZERO      = 2;

endpackage

// File: rtl/cpu_if.sv
// Instruction fetch bus: the CPU requests an address and the ROM answers with a valid-qualified word.
interface cpu_if
    import cpu_pkg::*;
#(
    parameter int IP_W = 8
);
    logic               instr_req;
    logic [IP_W-1:0]    instr_addr;
    logic               instr_valid;
    logic [INSTR_W-1:0] instruction;

    modport master (output instr_req, output instr_addr, input instr_valid, input instruction);
    modport slave  (input instr_req, input instr_addr, output instr_valid, output instruction);
endinterface

// File: rtl/cpu_call_stack.sv
// Return-address stack for CALL/RET; a push when full or a pop when empty leaves it unchanged.
module cpu_call_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int SLOTS = 1 << SP_W;

    logic [W-1:0]    mem_r [SLOTS];
    logic [SP_W-1:0] sp_r;

    assign full  = (sp_r == SP_W'(DEPTH));
    assign empty = (sp_r == {SP_W{1'b0}});
    assign top   = mem_r[sp_r - SP_W'(1)];

    // Stack storage and pointer update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sp_r <= {SP_W{1'b0}};
            for (int i = 0; i < SLOTS; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push && !full) begin
            mem_r[sp_r] <= push_data;
            sp_r        <= sp_r + SP_W'(1);
        end else if (pop && !empty) begin
            sp_r <= sp_r - SP_W'(1);
        end
    end
endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle CPU: FETCH/EXEC/HALTED sequencer, register file, flags and inline ALU.
// Optional macro CPU_CALL_STACK_EN builds the CALL/RET return stack; otherwise CALL/RET are illegal.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IP_W        = 8,
    parameter int NUM_REGS    = 8,
    parameter int DOUT_REG    = 7,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    cpu_if.master             bus,
    input  logic [DATA_W-1:0] din,
    input  logic [3:0]        gpi,
    output logic [DATA_W-1:0] reg_dout,
    output logic [7:0]        reg_gout,
    output logic [7:0]        reg_flag
);
    localparam logic [3:0] DOUT_IDX = 4'(DOUT_REG);
    localparam logic [4:0] NREG     = 5'(NUM_REGS);

    state_t             state_r, state_next_s;
    logic               req_r, halted_r, gpi0_prev_r;
    logic [IP_W-1:0]    ip_r, ip_inc_s, ip_next_s, addr_s;
    logic [INSTR_W-1:0] ir_r;
    logic [DATA_W-1:0]  regs_r [16];
    logic [DATA_W-1:0]  dout_r, a_val_s, b_val_s, res_s;
    logic               zero_r, carry_r, shovf_r, illegal_r, stk_over_r, stk_under_r;
    logic [3:0]         op_s, a_idx_s, b_idx_s;
    logic               wr_s, zero_upd_s, carry_upd_s, carry_new_s, shovf_upd_s, shovf_new_s;
    logic               halt_s, ill_s, over_s, under_s;
    logic [DATA_W:0]    sum_s, diff_s;
    logic [DATA_W+15:0] shl_s, shr_s;
    logic               fetch_fire_s, exec_fire_s, wr_en_s, resume_s;
    logic               unused_ok_s;

    assign op_s     = ir_r[OP_HI:OP_LO];
    assign a_idx_s  = ir_r[A_LO+3:A_LO];
    assign b_idx_s  = ir_r[B_LO+3:B_LO];
    assign addr_s   = ir_r[IP_W-1:0];
    assign ip_inc_s = ip_r + IP_W'(1);

    // Register indices beyond the implemented file read as zero
    assign a_val_s = ir_r[A_TYPE_BIT]
                   ? (({1'b0, a_idx_s} < NREG) ? regs_r[a_idx_s] : {DATA_W{1'b0}})
                   : DATA_W'(ir_r[A_HI:A_LO]);
    assign b_val_s = ir_r[B_TYPE_BIT]
                   ? (({1'b0, b_idx_s} < NREG) ? regs_r[b_idx_s] : {DATA_W{1'b0}})
                   : DATA_W'(ir_r[B_HI:B_LO]);

    // Shifts run in a 16-bit-padded field so every bit pushed out stays visible for shift_ovf
    assign sum_s  = {1'b0, b_val_s} + {1'b0, a_val_s};
    assign diff_s = {1'b0, b_val_s} - {1'b0, a_val_s};
    assign shl_s  = {16'h0000, b_val_s} << a_val_s[3:0];
    assign shr_s  = {b_val_s, 16'h0000} >> a_val_s[3:0];

    assign fetch_fire_s = enable && (state_r == S_FETCH) && bus.instr_valid;
    assign exec_fire_s  = enable && (state_r == S_EXEC);
    assign resume_s     = enable && gpi[0] && !gpi0_prev_r;
    assign wr_en_s      = exec_fire_s && wr_s && ir_r[B_TYPE_BIT] && ({1'b0, b_idx_s} < NREG);
    assign unused_ok_s  = ^{ir_r[9:8], gpi[3:1]};

`ifdef CPU_CALL_STACK_EN
    logic            push_s, pop_s, stk_full_s, stk_empty_s;
    logic [IP_W-1:0] stk_top_s;

    cpu_call_stack #(.DEPTH(STACK_DEPTH), .W(IP_W)) u_call_stack (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_s && exec_fire_s),
        .pop       (pop_s && exec_fire_s),
        .push_data (ip_inc_s),
        .top       (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );
`else
    logic [4:0] unused_depth_s;
    assign unused_depth_s = 5'(STACK_DEPTH);
`endif

    // Instruction decode and ALU: result, write enable, flag updates and next ip
    always_comb begin
        res_s       = b_val_s;
        wr_s        = 1'b0;
        zero_upd_s  = 1'b0;
        carry_upd_s = 1'b0;
        carry_new_s = carry_r;
        shovf_upd_s = 1'b0;
        shovf_new_s = 1'b0;
        halt_s      = 1'b0;
        ill_s       = 1'b0;
        over_s      = 1'b0;
        under_s     = 1'b0;
        ip_next_s   = ip_inc_s;
`ifdef CPU_CALL_STACK_EN
        push_s      = 1'b0;
        pop_s       = 1'b0;
`endif
        case (op_s)
            OP_NOP:  ;
            OP_MOV:  begin res_s = a_val_s; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_ADD:  begin res_s = sum_s[DATA_W-1:0]; carry_new_s = sum_s[DATA_W];
                           carry_upd_s = 1'b1; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_SUB:  begin res_s = diff_s[DATA_W-1:0]; carry_new_s = diff_s[DATA_W];
                           carry_upd_s = 1'b1; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_AND:  begin res_s = b_val_s & a_val_s; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_OR:   begin res_s = b_val_s | a_val_s; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_XOR:  begin res_s = b_val_s ^ a_val_s; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_SHL:  begin res_s = shl_s[DATA_W-1:0]; shovf_new_s = |shl_s[DATA_W+15:DATA_W];
                           shovf_upd_s = 1'b1; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_SHR:  begin res_s = shr_s[DATA_W+15:16]; shovf_new_s = |shr_s[15:0];
                           shovf_upd_s = 1'b1; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_JMP:  ip_next_s = addr_s;
            OP_JZ:   begin
                if (a_val_s == {DATA_W{1'b0}}) ip_next_s = addr_s;
                else ip_next_s = ip_inc_s;
            end
`ifdef CPU_CALL_STACK_EN
            OP_CALL: begin
                ip_next_s = addr_s;
                if (stk_full_s) over_s = 1'b1;
                else push_s = 1'b1;
            end
            OP_RET:  begin
                if (stk_empty_s) under_s = 1'b1;
                else begin pop_s = 1'b1; ip_next_s = stk_top_s; end
            end
`else
            OP_CALL, OP_RET: ill_s = 1'b1;
`endif
            OP_HALT: halt_s = 1'b1;
            OP_IN:   begin res_s = din; wr_s = 1'b1; zero_upd_s = 1'b1; end
            OP_ILL:  ill_s = 1'b1;
            default: ill_s = 1'b1;
        endcase
    end

    // Next-state logic; every transition requires enable
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FETCH:  if (fetch_fire_s) state_next_s = S_EXEC; else state_next_s = state_r;
            S_EXEC:   begin
                if (exec_fire_s) state_next_s = halt_s ? S_HALTED : S_FETCH;
                else state_next_s = state_r;
            end
            S_HALTED: if (resume_s) state_next_s = S_FETCH; else state_next_s = state_r;
            default:  state_next_s = S_FETCH;
        endcase
    end

    // FSM state and the status bits derived from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= S_FETCH;
            req_r    <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            req_r    <= (state_next_s == S_FETCH);
            halted_r <= (state_next_s == S_HALTED);
        end
    end

    // Architectural state: ip, instruction register, registers, flags, output mirror
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ip_r        <= {IP_W{1'b0}};
            ir_r        <= {INSTR_W{1'b0}};
            dout_r      <= {DATA_W{1'b0}};
            gpi0_prev_r <= 1'b0;
            zero_r      <= 1'b0;
            carry_r     <= 1'b0;
            shovf_r     <= 1'b0;
            illegal_r   <= 1'b0;
            stk_over_r  <= 1'b0;
            stk_under_r <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (enable) begin
            gpi0_prev_r <= gpi[0];
            dout_r      <= regs_r[DOUT_IDX];
            if (fetch_fire_s) ir_r <= bus.instruction;
            if (wr_en_s) regs_r[b_idx_s] <= res_s;
            if (exec_fire_s) begin
                ip_r        <= ip_next_s;
                illegal_r   <= illegal_r | ill_s;
                stk_over_r  <= stk_over_r | over_s;
                stk_under_r <= stk_under_r | under_s;
                if (zero_upd_s) zero_r <= (res_s == {DATA_W{1'b0}});
                if (carry_upd_s) carry_r <= carry_new_s;
                if (shovf_upd_s) shovf_r <= shovf_new_s;
            end
        end
    end

    assign bus.instr_req  = req_r;
    assign bus.instr_addr = ip_r;
    assign reg_dout       = dout_r;
    assign reg_gout       = {1'b1, halted_r, 6'b000000};

    // Flag byte assembly
    always_comb begin
        reg_flag                = 8'h00;
        reg_flag[FLG_ILLEGAL]   = illegal_r;
        reg_flag[FLG_STK_UNDER] = stk_under_r;
        reg_flag[FLG_STK_OVER]  = stk_over_r;
        reg_flag[FLG_SHIFT_OVF] = shovf_r;
        reg_flag[FLG_CARRY]     = carry_r;
        reg_flag[FLG_ZERO]      = zero_r;
    end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: a vector table of single instructions plus hand-written
// sequences for enable hold, HALT/resume, output latency, mid-EXEC reset and the call stack.
module tb_cpu_multicycle;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk, resetn, enable;
    logic [7:0] din, reg_dout, reg_gout, reg_flag;
    logic [3:0] gpi;
    int         total = 0;
    int         bad   = 0;

    typedef struct {
        logic [31:0] w;
        int          lat;
        logic [7:0]  addr;
        logic [7:0]  dout;
        logic [7:0]  flag;
    } vec_t;
    vec_t vecs[$];

    cpu_if #(.IP_W(8)) bus ();

    cpu_multicycle #(
        .DATA_W(8), .IP_W(8), .NUM_REGS(8), .DOUT_REG(7), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .bus      (bus),
        .din      (din),
        .gpi      (gpi),
        .reg_dout (reg_dout),
        .reg_gout (reg_gout),
        .reg_flag (reg_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic at, input logic [7:0] a,
                                        input logic bt, input logic [7:0] b, input logic [7:0] ad);
        return {op, at, a, bt, b, 2'b00, ad};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Acts as the ROM: waits for the request, answers after lat cycles, then lets EXEC run.
    task automatic run_instr(input logic [31:0] w, input int lat);
        int n;
        n = 0;
        while (bus.instr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", {31'd0, bus.instr_req}, 32'd1);
        repeat (lat) @(negedge clk);
        bus.instruction = w;
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic step(input string nm, input logic [31:0] w, input logic [7:0] ea, input logic [7:0] ef);
        run_instr(w, 0);
        @(negedge clk);
        chk({nm, "_addr"}, {24'd0, bus.instr_addr}, {24'd0, ea});
        chk({nm, "_flag"}, {24'd0, reg_flag}, {24'd0, ef});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'd5,   1, 8'd1, 8'h00), 3, 8'h01, 8'h00, 8'h00});
        vecs.push_back(vec_t'{enc(OP_ADD, 0, 8'd3,   1, 8'd1, 8'h00), 3, 8'h02, 8'h00, 8'h00});
        vecs.push_back(vec_t'{enc(OP_MOV, 1, 8'd1,   1, 8'd7, 8'h00), 0, 8'h03, 8'h08, 8'h00});
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'd200, 1, 8'd2, 8'h00), 1, 8'h04, 8'h08, 8'h00});
        vecs.push_back(vec_t'{enc(OP_ADD, 0, 8'd100, 1, 8'd2, 8'h00), 0, 8'h05, 8'h08, 8'h08});
        vecs.push_back(vec_t'{enc(OP_MOV, 1, 8'd2,   1, 8'd7, 8'h00), 2, 8'h06, 8'h2C, 8'h08});
        vecs.push_back(vec_t'{enc(OP_SUB, 0, 8'd44,  1, 8'd2, 8'h00), 0, 8'h07, 8'h2C, 8'h04});
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'h81,  1, 8'd3, 8'h00), 0, 8'h08, 8'h2C, 8'h00});
        vecs.push_back(vec_t'{enc(OP_SHL, 0, 8'd1,   1, 8'd3, 8'h00), 0, 8'h09, 8'h2C, 8'h10});
        vecs.push_back(vec_t'{enc(OP_SHR, 0, 8'd1,   1, 8'd3, 8'h00), 0, 8'h0A, 8'h2C, 8'h00});
        vecs.push_back(vec_t'{enc(OP_MOV, 1, 8'd3,   1, 8'd7, 8'h00), 0, 8'h0B, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'd0,   1, 8'd4, 8'h00), 0, 8'h0C, 8'h01, 8'h04});
        vecs.push_back(vec_t'{enc(OP_JZ,  1, 8'd4,   0, 8'd0, 8'h40), 0, 8'h40, 8'h01, 8'h04});
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'd1,   1, 8'd4, 8'h00), 0, 8'h41, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_JZ,  1, 8'd4,   0, 8'd0, 8'h10), 0, 8'h42, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_JMP, 0, 8'd0,   0, 8'd0, 8'hFF), 0, 8'hFF, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_NOP, 0, 8'd0,   0, 8'd0, 8'h00), 0, 8'h00, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'hF0,  1, 8'd5, 8'h00), 0, 8'h01, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_AND, 0, 8'h3C,  1, 8'd5, 8'h00), 0, 8'h02, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_OR,  0, 8'h03,  1, 8'd5, 8'h00), 0, 8'h03, 8'h01, 8'h00});
        vecs.push_back(vec_t'{enc(OP_XOR, 0, 8'h33,  1, 8'd5, 8'h00), 0, 8'h04, 8'h01, 8'h04});
        vecs.push_back(vec_t'{enc(OP_ADD, 0, 8'h0C,  0, 8'hF5, 8'h00), 0, 8'h05, 8'h01, 8'h08});
        vecs.push_back(vec_t'{enc(OP_MOV, 1, 8'd5,   1, 8'd7, 8'h00), 0, 8'h06, 8'h00, 8'h0C});
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'd9,   1, 8'd7, 8'h00), 0, 8'h07, 8'h09, 8'h08});
        vecs.push_back(vec_t'{enc(OP_MOV, 0, 8'h55,  1, 8'd12, 8'h00), 0, 8'h08, 8'h09, 8'h08});
        vecs.push_back(vec_t'{enc(OP_MOV, 1, 8'd12,  1, 8'd7, 8'h00), 0, 8'h09, 8'h00, 8'h0C});
        vecs.push_back(vec_t'{enc(OP_ILL, 0, 8'd0,   0, 8'd0, 8'h00), 0, 8'h0A, 8'h00, 8'h8C});

        resetn = 1'b0; enable = 1'b1; din = 8'h00; gpi = 4'h0;
        bus.instr_valid = 1'b0; bus.instruction = 32'h0000_0000;
        @(negedge clk);
        chk("rst_req",  {31'd0, bus.instr_req}, 32'd0);
        chk("rst_addr", {24'd0, bus.instr_addr}, 32'd0);
        chk("rst_dout", {24'd0, reg_dout}, 32'd0);
        chk("rst_gout", {24'd0, reg_gout}, 32'h80);
        chk("rst_flag", {24'd0, reg_flag}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'd0, bus.instr_req}, 32'd1);

        // Valid word offered while disabled must not be taken
        enable = 1'b0;
        bus.instruction = vecs[0].w;
        bus.instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("hold_addr", {24'd0, bus.instr_addr}, 32'd0);
        chk("hold_req",  {31'd0, bus.instr_req}, 32'd1);
        bus.instr_valid = 1'b0;
        enable = 1'b1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].w, vecs[i].lat);
            @(negedge clk);
            chk($sformatf("v%0d_addr", i), {24'd0, bus.instr_addr}, {24'd0, vecs[i].addr});
            chk($sformatf("v%0d_dout", i), {24'd0, reg_dout}, {24'd0, vecs[i].dout});
            chk($sformatf("v%0d_flag", i), {24'd0, reg_flag}, {24'd0, vecs[i].flag});
        end

        // HALT, then a 3-cycle gpi[0] pulse gives exactly one resume
        run_instr(enc(OP_HALT, 0, 8'd0, 0, 8'd0, 8'h00), 0);
        @(negedge clk);
        chk("halt_gout", {24'd0, reg_gout}, 32'hC0);
        chk("halt_req",  {31'd0, bus.instr_req}, 32'd0);
        chk("halt_addr", {24'd0, bus.instr_addr}, 32'h0B);
        gpi = 4'h1;
        repeat (3) @(negedge clk);
        chk("resume_gout", {24'd0, reg_gout}, 32'h80);
        chk("resume_req",  {31'd0, bus.instr_req}, 32'd1);
        run_instr(enc(OP_HALT, 0, 8'd0, 0, 8'd0, 8'h00), 0);
        repeat (3) @(negedge clk);
        chk("level_no_resume", {24'd0, reg_gout}, 32'hC0);
        gpi = 4'h0;
        @(negedge clk);
        gpi = 4'h1;
        repeat (2) @(negedge clk);
        chk("edge_resume_gout", {24'd0, reg_gout}, 32'h80);
        chk("edge_resume_addr", {24'd0, bus.instr_addr}, 32'h0C);
        gpi = 4'h0;

        // IN to the mirrored register shows up on reg_dout one cycle after the write
        din = 8'hA5;
        run_instr(enc(OP_IN, 0, 8'd0, 1, 8'd7, 8'h00), 0);
        chk("in_dout_early", {24'd0, reg_dout}, 32'h00);
        @(negedge clk);
        chk("in_dout", {24'd0, reg_dout}, 32'hA5);
        chk("in_flag", {24'd0, reg_flag}, 32'h88);
        chk("in_addr", {24'd0, bus.instr_addr}, 32'h0D);

        // Reset asserted while in EXEC
        while (bus.instr_req !== 1'b1) @(negedge clk);
        bus.instruction = enc(OP_MOV, 0, 8'h11, 1, 8'd7, 8'h00);
        bus.instr_valid = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_req",  {31'd0, bus.instr_req}, 32'd0);
        chk("mid_rst_addr", {24'd0, bus.instr_addr}, 32'd0);
        chk("mid_rst_dout", {24'd0, reg_dout}, 32'd0);
        chk("mid_rst_gout", {24'd0, reg_gout}, 32'h80);
        chk("mid_rst_flag", {24'd0, reg_flag}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_dout_after", {24'd0, reg_dout}, 32'd0);

        for (int i = 0; i < 5; i++) run_instr(enc(OP_NOP, 0, 8'd0, 0, 8'd0, 8'h00), 0);
        @(negedge clk);
        chk("nop_addr", {24'd0, bus.instr_addr}, 32'h05);

`ifdef CPU_CALL_STACK_EN
        step("call", enc(OP_CALL, 0, 8'd0, 0, 8'd0, 8'h20), 8'h20, 8'h00);
        step("ret",  enc(OP_RET,  0, 8'd0, 0, 8'd0, 8'h00), 8'h06, 8'h00);
        for (int i = 0; i <= DEPTH; i++) begin
            step($sformatf("ncall%0d", i), enc(OP_CALL, 0, 8'd0, 0, 8'd0, 8'h20), 8'h20,
                 (i == DEPTH) ? 8'h20 : 8'h00);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step($sformatf("nret%0d", i), enc(OP_RET, 0, 8'd0, 0, 8'd0, 8'h00),
                 (i < DEPTH - 1) ? 8'h21 : 8'h07, 8'h20);
        end
        step("under", enc(OP_RET, 0, 8'd0, 0, 8'd0, 8'h00), 8'h08, 8'h60);
`else
        step("call_ill", enc(OP_CALL, 0, 8'd0, 0, 8'd0, 8'h20), 8'h06, 8'h80);
        step("ret_ill",  enc(OP_RET,  0, 8'd0, 0, 8'd0, 8'h00), 8'h07, 8'h80);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
